// File: rtl/fixed_bus_pkg.sv
// Shared types and helpers for the fixed-point lane bus streamer.
// Bus geometry, FSM state encoding and small index/size functions.
package fixed_bus_pkg;

    localparam int BUS_NUM          = 8;
    localparam int BUS_NUM_WIDTH    = 3;
    localparam int FIXED_DATA_WIDTH = 8;
    localparam int DATA_NUM_WIDTH   = 10;
    localparam int MEM_WIDTH        = BUS_NUM * FIXED_DATA_WIDTH;
    localparam int MEM_DEPTH        = 512;
    localparam int MEM_ADDR_WIDTH   = 9;
    localparam int WORDS_WIDTH      = DATA_NUM_WIDTH - BUS_NUM_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int lane_lo(input int lane);
        return lane * FIXED_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/fixed_bus_streamer_lane_tail_mask.sv
// Per-lane valid mask for the final, possibly partial, bus beat.
// Lanes at or above the tail count are cleared only on the last beat.
import fixed_bus_pkg::*;

module lane_tail_mask (
    input  logic [BUS_NUM_WIDTH-1:0] tail_i,
    input  logic                     last_i,
    output logic [BUS_NUM-1:0]       mask_o
);

    always_comb begin
        mask_o = '1;
        for (int i = 0; i < BUS_NUM; i++) begin
            mask_o[i] = !last_i
                      || (tail_i == '0)
                      || (BUS_NUM_WIDTH'(i) < tail_i);
        end
    end

endmodule

// File: rtl/fixed_bus_streamer.sv
// Streams an SRAM-resident element vector onto the fixed-point lane bus.
// FSM issues reads; a one-stage register drives the bus with tail masking.
import fixed_bus_pkg::*;

module fixed_bus_streamer (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_NUM_WIDTH-1:0] data_num,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    input  logic [MEM_WIDTH-1:0]      mem_rdata,
    output logic [MEM_WIDTH-1:0]      out_fixed_data,
    output logic [BUS_NUM-1:0]        out_fixed_data_vld
);

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORDS_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
    logic [BUS_NUM_WIDTH-1:0]  tail_q, tail_d;
    logic [WORDS_WIDTH-1:0]    cap_words;
    logic                      rd_last;

    logic                      ren_d1_q;
    logic                      last_d1_q;
    logic                      out_last_q;
    logic [MEM_WIDTH-1:0]      out_data_q, out_data_d;
    logic [BUS_NUM-1:0]        out_vld_q, out_vld_d;
    logic [BUS_NUM-1:0]        mask;

    assign cap_words = WORDS_WIDTH'(ceil_div(int'(data_num), BUS_NUM));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_cnt_d = rd_cnt_q;
        tail_d   = tail_q;
        rd_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    rd_cnt_d = cap_words;
                    tail_d   = data_num[BUS_NUM_WIDTH-1:0];
                    state_d  = (cap_words == '0) ? DONE : READ;
                end
            end
            READ: begin
                rd_last  = (rd_cnt_q == WORDS_WIDTH'(1));
                rd_cnt_d = rd_cnt_q - 1'b1;
                if (rd_last) begin
                    state_d = DRAIN;
                end else if (addr_q == MEM_ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            // The output register holds the last beat this cycle.
            DRAIN: begin
                if (out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lane_tail_mask u_mask (
        .tail_i (tail_q),
        .last_i (last_d1_q),
        .mask_o (mask)
    );

    assign out_vld_d = ren_d1_q ? mask : '0;

    for (genvar i = 0; i < BUS_NUM; i++) begin : g_lane
        assign out_data_d[lane_lo(i) +: FIXED_DATA_WIDTH] =
            out_vld_d[i] ? mem_rdata[lane_lo(i) +: FIXED_DATA_WIDTH]
                         : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            tail_q     <= '0;
            ren_d1_q   <= 1'b0;
            last_d1_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            tail_q     <= tail_d;
            ren_d1_q   <= (state_q == READ);
            last_d1_q  <= rd_last;
            out_last_q <= ren_d1_q && last_d1_q;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
    assign mem_ren            = (state_q == READ);
    assign mem_raddr          = addr_q;
    assign out_fixed_data     = out_data_q;
    assign out_fixed_data_vld = out_vld_q;

endmodule

// File: tb/tb_fixed_bus_streamer.sv
// Scoreboard bench for fixed_bus_streamer: directed transfers,
// expected beats queued at launch and checked by a bus monitor.
module tb_fixed_bus_streamer;

    localparam int BN = 8;
    localparam int MW = 64;
    localparam int AW = 9;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] data_num = '0;
    logic          busy;
    logic          done;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [MW-1:0] mem_rdata = '0;
    logic [MW-1:0] out_fixed_data;
    logic [BN-1:0] out_fixed_data_vld;

    always #5 clk = ~clk;

    fixed_bus_streamer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_addr          (base_addr),
        .data_num           (data_num),
        .busy               (busy),
        .done               (done),
        .mem_ren            (mem_ren),
        .mem_raddr          (mem_raddr),
        .mem_rdata          (mem_rdata),
        .out_fixed_data     (out_fixed_data),
        .out_fixed_data_vld (out_fixed_data_vld)
    );

    logic [MW-1:0] sram [512];

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= sram[mem_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MW-1:0] data;
        logic [BN-1:0] vld;
        int            at;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Bus monitor: every beat must match the head of the queue.
    always @(negedge clk) begin : mon
        beat_t b;
        if (out_fixed_data_vld != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat cyc %0d got %h/%h want none",
                         cyc, out_fixed_data, out_fixed_data_vld);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", out_fixed_data, b.data);
                chk("beat_vld", 64'(out_fixed_data_vld), 64'(b.vld));
                chk("beat_cycle", 64'(cyc), 64'(b.at));
            end
        end else if (out_fixed_data != '0) begin
            chk("idle_data", out_fixed_data, 64'h0);
        end
    end

    int c1;
    int ren_n, done_n, done_at, busy_n, busy_first, busy_last;
    logic [AW-1:0] addrs[$];

    task automatic push(input logic [MW-1:0] d,
                        input logic [BN-1:0] v,
                        input int k);
        exp_q.push_back('{data: d, vld: v, at: c1 + k - 1});
    endtask

    // Caller is at a negedge; start is high for exactly one edge.
    task automatic launch(input logic [AW-1:0] b,
                          input logic [DW-1:0] n);
        base_addr = b;
        data_num  = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c1    = cyc;
    endtask

    task automatic observe(input int n, input int rep_at,
                           input logic [AW-1:0] rb,
                           input logic [DW-1:0] rn);
        ren_n = 0; done_n = 0; done_at = 0;
        busy_n = 0; busy_first = 0; busy_last = 0;
        addrs.delete();
        for (int k = 1; k <= n; k++) begin
            if (mem_ren) begin
                ren_n++;
                addrs.push_back(mem_raddr);
            end
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (busy) begin
                busy_n++;
                if (busy_first == 0) busy_first = k;
                busy_last = k;
            end
            if (k == rep_at) begin
                base_addr = rb;
                data_num  = rn;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_obs(input string t, input int eren,
                             input int edone, input int ebusy);
        chk({t, "_ren_count"}, 64'(ren_n), 64'(eren));
        chk({t, "_done_count"}, 64'(done_n), (edone > 0) ? 64'd1 : 64'd0);
        chk({t, "_done_cycle"}, 64'(done_at), 64'(edone));
        chk({t, "_busy_cycles"}, 64'(busy_n), 64'(ebusy));
        if (ebusy > 0) begin
            chk({t, "_busy_first"}, 64'(busy_first), 64'd1);
            chk({t, "_busy_last"}, 64'(busy_last), 64'(edone));
        end
    endtask

    task automatic check_addr(input string t, input int i,
                              input logic [AW-1:0] ea);
        logic [AW-1:0] a;
        a = (addrs.size() > i) ? addrs[i] : 'x;
        chk({t, "_raddr"}, 64'(a), 64'(ea));
    endtask

    task automatic check_outputs_zero(input string t);
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_done"}, 64'(done), 64'd0);
        chk({t, "_ren"}, 64'(mem_ren), 64'd0);
        chk({t, "_raddr"}, 64'(mem_raddr), 64'd0);
        chk({t, "_data"}, out_fixed_data, 64'h0);
        chk({t, "_vld"}, 64'(out_fixed_data_vld), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = 64'h5A5A_0000_0000_0000 | 64'(i);
        sram[9'h010] = 64'h0807060504030201;
        sram[9'h011] = 64'h100F0E0D0C0B0A09;
        sram[9'h020] = 64'hF0E0D0C0B0A09080;
        sram[9'h021] = 64'h8877665544332211;
        sram[9'h030] = 64'hDEADBEEF00000001;
        sram[9'h031] = 64'hDEADBEEF00000002;
        sram[9'h1FF] = 64'hAAAAAAAAAAAAAAAA;
        sram[9'h000] = 64'hBBBBBBBBBBBBBBBB;
        sram[9'h001] = 64'hCCCCCCCCCCCCCCCC;

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two full words
        launch(9'h010, 10'd16);
        push(64'h0807060504030201, 8'hFF, 3);
        push(64'h100F0E0D0C0B0A09, 8'hFF, 4);
        observe(6, 0, '0, '0);
        check_obs("full", 2, 5, 5);
        check_addr("full0", 0, 9'h010);
        check_addr("full1", 1, 9'h011);

        // Partial final word, 5 valid lanes
        launch(9'h020, 10'd13);
        push(64'hF0E0D0C0B0A09080, 8'hFF, 3);
        push(64'h0000005544332211, 8'h1F, 4);
        observe(6, 0, '0, '0);
        check_obs("tail", 2, 5, 5);

        // Zero length; start in the DONE cycle must be dropped
        launch(9'h000, 10'd0);
        observe(4, 1, 9'h010, 10'd8);
        check_obs("zero", 0, 1, 1);

        // Address wrap at the top of the SRAM
        launch(9'h1FF, 10'd24);
        push(64'hAAAAAAAAAAAAAAAA, 8'hFF, 3);
        push(64'hBBBBBBBBBBBBBBBB, 8'hFF, 4);
        push(64'hCCCCCCCCCCCCCCCC, 8'hFF, 5);
        observe(7, 0, '0, '0);
        check_obs("wrap", 3, 6, 6);
        check_addr("wrap0", 0, 9'h1FF);
        check_addr("wrap1", 1, 9'h000);
        check_addr("wrap2", 2, 9'h001);

        // Restart while busy is ignored; restart right after done runs
        launch(9'h030, 10'd16);
        push(64'hDEADBEEF00000001, 8'hFF, 3);
        push(64'hDEADBEEF00000002, 8'hFF, 4);
        observe(5, 2, 9'h020, 10'd13);
        check_obs("busy", 2, 5, 5);
        check_addr("busy0", 0, 9'h030);
        check_addr("busy1", 1, 9'h031);
        launch(9'h010, 10'd8);
        push(64'h0807060504030201, 8'hFF, 3);
        observe(5, 0, '0, '0);
        check_obs("after", 1, 4, 4);
        check_addr("after0", 0, 9'h010);

        // Reset during READ aborts everything
        launch(9'h040, 10'd64);
        observe(1, 0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs_zero("abort");
        observe(12, 0, '0, '0);
        check_obs("abort", 0, 0, 0);
        launch(9'h010, 10'd16);
        push(64'h0807060504030201, 8'hFF, 3);
        push(64'h100F0E0D0C0B0A09, 8'hFF, 4);
        observe(6, 0, '0, '0);
        check_obs("rerun", 2, 5, 5);

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
